// File: rtl/i2cs_pkg.sv
// rtl/i2cs_pkg.sv - shared types and constants for the i2c register-page slave
package i2cs_pkg;

   localparam int BYTE_W = 8;
   localparam int CNT_W  = 3;

   localparam logic I2C_RW_READ = 1'b1;
   localparam logic I2C_ACK     = 1'b0;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_DEV     = 4'd1,
      ST_DEV_ACK = 4'd2,
      ST_REG     = 4'd3,
      ST_REG_ACK = 4'd4,
      ST_WR      = 4'd5,
      ST_WR_ACK  = 4'd6,
      ST_RD      = 4'd7,
      ST_RD_ACK  = 4'd8,
      ST_IGNORE  = 4'd9
   } state_t;

endpackage

// File: rtl/i2cs_bus_filt.sv
// rtl/i2cs_bus_filt.sv - SCL/SDA synchronizer, glitch filter and bus event detect
module i2cs_bus_filt #(
   parameter int SYNC_STG = 2,
   parameter int FILT_LEN = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic scl,
   input  logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop,
   output logic sda_lvl
);

   logic [SYNC_STG-1:0] scl_sync, sda_sync;
   logic [FILT_LEN-1:0] scl_win, sda_win;
   logic                scl_lvl, scl_q, sda_q;

   // Everything resets to the idle-bus level so release of reset never looks like a START.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_win  <= '1;
         sda_win  <= '1;
         scl_lvl  <= 1'b1;
         sda_lvl  <= 1'b1;
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STG-2:0], scl};
         sda_sync <= {sda_sync[SYNC_STG-2:0], sda};
         scl_win  <= {scl_win[FILT_LEN-2:0], scl_sync[SYNC_STG-1]};
         sda_win  <= {sda_win[FILT_LEN-2:0], sda_sync[SYNC_STG-1]};
         if (&scl_win)
            scl_lvl <= 1'b1;
         else if (!(|scl_win))
            scl_lvl <= 1'b0;
         if (&sda_win)
            sda_lvl <= 1'b1;
         else if (!(|sda_win))
            sda_lvl <= 1'b0;
         scl_q <= scl_lvl;
         sda_q <= sda_lvl;
      end
   end

   assign scl_rise = scl_lvl & ~scl_q;
   assign scl_fall = ~scl_lvl & scl_q;
   // SCL must be high both before and after the SDA edge to qualify as START/STOP.
   assign start    = scl_lvl & scl_q & sda_q & ~sda_lvl;
   assign stop     = scl_lvl & scl_q & ~sda_q & sda_lvl;

endmodule

// File: rtl/i2cs_reg_slave.sv
// rtl/i2cs_reg_slave.sv - i2c slave decoding device/pointer/data bytes onto a register page
module i2cs_reg_slave
   import i2cs_pkg::*;
#(
   parameter logic [6:0] DEV_ID   = 7'h3C,
   parameter int         SYNC_STG = 2,
   parameter int         FILT_LEN = 3,
   parameter int         AUTO_INC = 1
) (
   input  logic              i2cs_clk,
   input  logic              i2cs_rst_n,
   input  logic              i_scl,
   input  logic              i_sda,
   output logic              o_sda_en,
   output logic [BYTE_W-1:0] o_reg_wr_addr,
   output logic [BYTE_W-1:0] o_reg_wr_data,
   output logic              o_reg_wr_en,
   output logic [BYTE_W-1:0] o_reg_rd_addr,
   output logic              o_reg_rd_en,
   input  logic [BYTE_W-1:0] i_reg_rd_data,
   output logic              o_busy
);

   localparam logic [BYTE_W-1:0] PTR_STEP = (AUTO_INC != 0) ? 8'd1 : 8'd0;

   logic              scl_rise, scl_fall, start, stop, sda_lvl;
   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [BYTE_W-2:0] rx_sh;
   logic [BYTE_W-1:0] tx_sh, ptr, rx_byte;
   logic              mack, load_pend, rx_state, byte_end;

   i2cs_bus_filt #(.SYNC_STG(SYNC_STG), .FILT_LEN(FILT_LEN)) u_filt (
      .clk      (i2cs_clk),
      .rst_n    (i2cs_rst_n),
      .scl      (i_scl),
      .sda      (i_sda),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (start),
      .stop     (stop),
      .sda_lvl  (sda_lvl)
   );

   assign rx_byte       = {rx_sh, sda_lvl};
   assign byte_end      = &cnt;
   assign rx_state      = (state == ST_DEV) || (state == ST_REG) || (state == ST_WR);
   assign o_reg_rd_addr = ptr;

   always_ff @(posedge i2cs_clk or negedge i2cs_rst_n) begin
      if (!i2cs_rst_n) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         rx_sh         <= '0;
         tx_sh         <= '0;
         ptr           <= '0;
         mack          <= 1'b0;
         load_pend     <= 1'b0;
         o_sda_en      <= 1'b0;
         o_reg_wr_addr <= '0;
         o_reg_wr_data <= '0;
         o_reg_wr_en   <= 1'b0;
         o_reg_rd_en   <= 1'b0;
         o_busy        <= 1'b0;
      end else begin
         o_reg_wr_en <= 1'b0;
         o_reg_rd_en <= 1'b0;
         load_pend   <= 1'b0;
         if (start) begin
            state    <= ST_DEV;
            cnt      <= '0;
            mack     <= 1'b0;
            o_sda_en <= 1'b0;
         end else if (stop) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            mack     <= 1'b0;
            o_sda_en <= 1'b0;
            o_busy   <= 1'b0;
         end else if (load_pend) begin
            // Read data arrives one cycle after the strobe; MSB goes on the wire right away.
            tx_sh    <= {i_reg_rd_data[BYTE_W-2:0], 1'b0};
            o_sda_en <= ~i_reg_rd_data[BYTE_W-1];
         end else begin
            if (scl_rise && (rx_state || state == ST_RD))
               cnt <= cnt + 1'b1;
            if (scl_rise && rx_state)
               rx_sh <= rx_byte[BYTE_W-2:0];
            case (state)
               ST_DEV: begin
                  if (scl_rise && byte_end) begin
                     if (rx_byte[BYTE_W-1:1] == DEV_ID) begin
                        state  <= ST_DEV_ACK;
                        o_busy <= 1'b1;
                     end else begin
                        state  <= ST_IGNORE;
                     end
                  end
               end
               ST_REG: begin
                  if (scl_rise && byte_end) begin
                     ptr   <= rx_byte;
                     state <= ST_REG_ACK;
                  end
               end
               ST_WR: begin
                  if (scl_rise && byte_end) begin
                     o_reg_wr_addr <= ptr;
                     o_reg_wr_data <= rx_byte;
                     o_reg_wr_en   <= 1'b1;
                     ptr           <= ptr + PTR_STEP;
                     state         <= ST_WR_ACK;
                  end
               end
               // o_sda_en doubles as the ACK phase flag: first fall drives, second releases.
               ST_DEV_ACK, ST_REG_ACK, ST_WR_ACK: begin
                  if (scl_fall) begin
                     if (!o_sda_en) begin
                        o_sda_en <= 1'b1;
                     end else begin
                        o_sda_en <= 1'b0;
                        cnt      <= '0;
                        if (state == ST_DEV_ACK && rx_sh[0] == I2C_RW_READ) begin
                           o_reg_rd_en <= 1'b1;
                           load_pend   <= 1'b1;
                           state       <= ST_RD;
                        end else if (state == ST_DEV_ACK) begin
                           state <= ST_REG;
                        end else begin
                           state <= ST_WR;
                        end
                     end
                  end
               end
               ST_RD: begin
                  if (scl_rise && byte_end) begin
                     state <= ST_RD_ACK;
                  end else if (scl_fall) begin
                     o_sda_en <= ~tx_sh[BYTE_W-1];
                     tx_sh    <= {tx_sh[BYTE_W-2:0], 1'b0};
                  end
               end
               ST_RD_ACK: begin
                  if (scl_rise) begin
                     if (sda_lvl == I2C_ACK) begin
                        mack <= 1'b1;
                        ptr  <= ptr + PTR_STEP;
                     end else begin
                        state <= ST_IGNORE;
                     end
                  end else if (scl_fall) begin
                     if (mack) begin
                        mack        <= 1'b0;
                        o_reg_rd_en <= 1'b1;
                        load_pend   <= 1'b1;
                        state       <= ST_RD;
                     end else begin
                        o_sda_en <= 1'b0;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2cs_reg_slave.sv
// tb/tb_i2cs_reg_slave.sv - randomized bench for i2cs_reg_slave against a transaction-level model
module tb_i2cs_reg_slave;

   localparam int Q = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic m_scl = 1'b1, m_sda = 1'b1, sda_bus;
   logic sda_en_a, wr_en_a, rd_en_a, busy_a;
   logic sda_en_b, wr_en_b, rd_en_b, busy_b;
   logic [7:0] wr_addr_a, wr_data_a, rd_addr_a, rd_data_a;
   logic [7:0] wr_addr_b, wr_data_b, rd_addr_b, rd_data_b;

   int total = 0, bad = 0;
   int en_cnt_a = 0, en_cnt_b = 0, busy_cnt_a = 0, busy_cnt_b = 0;
   bit glitch_on = 1'b0;
   logic [7:0] mem_a [256];
   logic [7:0] mem_b [256];
   logic [7:0] mptr [2];
   logic [15:0] obs_wr_a[$], obs_wr_b[$], obs_rd_a[$], obs_rd_b[$];
   logic [15:0] exp_wr_a[$], exp_wr_b[$], exp_rd_a[$], exp_rd_b[$];

   always #5 clk = ~clk;
   assign sda_bus = m_sda & ~sda_en_a & ~sda_en_b;

   i2cs_reg_slave u_dut (
      .i2cs_clk(clk), .i2cs_rst_n(rst_n), .i_scl(m_scl), .i_sda(sda_bus),
      .o_sda_en(sda_en_a), .o_reg_wr_addr(wr_addr_a), .o_reg_wr_data(wr_data_a),
      .o_reg_wr_en(wr_en_a), .o_reg_rd_addr(rd_addr_a), .o_reg_rd_en(rd_en_a),
      .i_reg_rd_data(rd_data_a), .o_busy(busy_a)
   );

   i2cs_reg_slave #(.DEV_ID(7'h51), .AUTO_INC(0)) u_dut_ni (
      .i2cs_clk(clk), .i2cs_rst_n(rst_n), .i_scl(m_scl), .i_sda(sda_bus),
      .o_sda_en(sda_en_b), .o_reg_wr_addr(wr_addr_b), .o_reg_wr_data(wr_data_b),
      .o_reg_wr_en(wr_en_b), .o_reg_rd_addr(rd_addr_b), .o_reg_rd_en(rd_en_b),
      .i_reg_rd_data(rd_data_b), .o_busy(busy_b)
   );

   // Register-file responder and event logger; read data is valid only in the cycle after the strobe.
   always @(negedge clk) begin
      if (wr_en_a) obs_wr_a.push_back({wr_addr_a, wr_data_a});
      if (wr_en_b) obs_wr_b.push_back({wr_addr_b, wr_data_b});
      if (rd_en_a) obs_rd_a.push_back({8'h00, rd_addr_a});
      if (rd_en_b) obs_rd_b.push_back({8'h00, rd_addr_b});
      rd_data_a = rd_en_a ? mem_a[rd_addr_a] : 8'($urandom);
      rd_data_b = rd_en_b ? mem_b[rd_addr_b] : 8'($urandom);
      if (sda_en_a) en_cnt_a++;
      if (sda_en_b) en_cnt_b++;
      if (busy_a) busy_cnt_a++;
      if (busy_b) busy_cnt_b++;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] id_of(input int dev);
      return (dev == 0) ? 7'h3C : 7'h51;
   endfunction

   function automatic logic [7:0] inc_of(input int dev);
      return (dev == 0) ? 8'd1 : 8'd0;
   endfunction

   function automatic logic [7:0] memv(input int dev, input logic [7:0] a);
      return (dev == 0) ? mem_a[a] : mem_b[a];
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b, output logic rb);
      cyc(Q);
      m_sda = b;
      if (glitch_on) begin
         cyc(3); m_scl = 1'b1; cyc(2); m_scl = 1'b0; cyc(Q - 5);
      end else begin
         cyc(Q);
      end
      m_scl = 1'b1;
      if (glitch_on && !b) begin
         cyc(3); m_sda = 1'b1; cyc(2); m_sda = 1'b0; cyc(Q - 5);
      end else begin
         cyc(Q);
      end
      rb = sda_bus;
      cyc(Q);
      m_scl = 1'b0;
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; cyc(Q);
      m_scl = 1'b1; cyc(Q);
      m_sda = 1'b0; cyc(Q);
      m_scl = 1'b0;
   endtask

   task automatic i2c_stop();
      cyc(Q); m_sda = 1'b0;
      cyc(Q); m_scl = 1'b1;
      cyc(Q); m_sda = 1'b1;
      cyc(2 * Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) send_bit(b[i], r);
      send_bit(1'b1, r);
      ack = ~r;
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] b);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         send_bit(1'b1, r);
         b[i] = r;
      end
      send_bit(nack, r);
   endtask

   task automatic push_wr(input int dev, input logic [15:0] v);
      if (dev == 0) exp_wr_a.push_back(v); else exp_wr_b.push_back(v);
   endtask

   task automatic push_rd(input int dev, input logic [7:0] a);
      if (dev == 0) exp_rd_a.push_back({8'h00, a}); else exp_rd_b.push_back({8'h00, a});
   endtask

   task automatic cmp_q(input string tag, input logic [15:0] obs[$], input logic [15:0] exp[$]);
      check_val({tag, "_cnt"}, obs.size(), exp.size());
      for (int i = 0; i < exp.size() && i < obs.size(); i++)
         check_val(tag, obs[i], exp[i]);
   endtask

   task automatic cmp_events(input string tag);
      cyc(4);
      cmp_q({tag, "/wr_a"}, obs_wr_a, exp_wr_a);
      cmp_q({tag, "/wr_b"}, obs_wr_b, exp_wr_b);
      cmp_q({tag, "/rd_a"}, obs_rd_a, exp_rd_a);
      cmp_q({tag, "/rd_b"}, obs_rd_b, exp_rd_b);
      obs_wr_a.delete(); obs_wr_b.delete(); obs_rd_a.delete(); obs_rd_b.delete();
      exp_wr_a.delete(); exp_wr_b.delete(); exp_rd_a.delete(); exp_rd_b.delete();
   endtask

   task automatic do_write(input int dev, input logic [7:0] ra, input logic [7:0] d[$], input bit do_stop);
      logic a;
      i2c_start();
      write_byte({id_of(dev), 1'b0}, a); check_val("wr_dev_ack", a, 1'b1);
      write_byte(ra, a);                 check_val("wr_reg_ack", a, 1'b1);
      mptr[dev] = ra;
      foreach (d[k]) begin
         write_byte(d[k], a); check_val("wr_data_ack", a, 1'b1);
         push_wr(dev, {mptr[dev], d[k]});
         mptr[dev] = mptr[dev] + inc_of(dev);
      end
      if (do_stop) i2c_stop();
   endtask

   task automatic do_read(input int dev, input bit set_ptr, input logic [7:0] ra, input int n);
      logic a;
      logic [7:0] b;
      i2c_start();
      if (set_ptr) begin
         write_byte({id_of(dev), 1'b0}, a); check_val("rd_devw_ack", a, 1'b1);
         write_byte(ra, a);                 check_val("rd_reg_ack", a, 1'b1);
         mptr[dev] = ra;
         i2c_start();
      end
      write_byte({id_of(dev), 1'b1}, a); check_val("rd_devr_ack", a, 1'b1);
      for (int k = 0; k < n; k++) begin
         read_byte(k == n - 1, b);
         check_val("rd_data", b, memv(dev, mptr[dev]));
         push_rd(dev, mptr[dev]);
         if (k != n - 1) mptr[dev] = mptr[dev] + inc_of(dev);
      end
      cyc(2);
      check_val("rd_release", sda_en_a | sda_en_b, 1'b0);
      i2c_stop();
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] d[$];
      logic [7:0] b;
      logic a, r, found;
      int e0, e1, b0, b1;

      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 8'($urandom);
         mem_b[i] = 8'($urandom);
      end
      mem_a[8'h20] = 8'hC3;
      mem_a[8'h21] = 8'h3C;
      mptr[0] = 8'h00;
      mptr[1] = 8'h00;

      cyc(3);
      check_val("rst_sda_en", sda_en_a, 1'b0);
      check_val("rst_wr_en", wr_en_a, 1'b0);
      check_val("rst_rd_en", rd_en_a, 1'b0);
      check_val("rst_busy", busy_a, 1'b0);
      check_val("rst_wr_addr", wr_addr_a, 8'h00);
      check_val("rst_wr_data", wr_data_a, 8'h00);
      check_val("rst_rd_addr", rd_addr_a, 8'h00);
      rst_n = 1'b1;
      cyc(4 * Q);

      d = {8'hA5, 8'h5A};
      do_write(0, 8'h10, d, 1'b0);
      check_val("busy_before_stop", busy_a, 1'b1);
      i2c_stop();
      check_val("busy_after_stop", busy_a, 1'b0);
      cmp_events("dir_write");

      do_read(0, 1'b1, 8'h20, 2);
      cmp_events("dir_read");

      e0 = en_cnt_a; e1 = en_cnt_b; b0 = busy_cnt_a; b1 = busy_cnt_b;
      i2c_start();
      write_byte(8'h7A, a); check_val("wrong_id_ack", a, 1'b0);
      write_byte(8'h10, a); check_val("wrong_id_reg_ack", a, 1'b0);
      write_byte(8'h55, a); check_val("wrong_id_data_ack", a, 1'b0);
      i2c_stop();
      check_val("wrong_id_sda_en", (en_cnt_a - e0) + (en_cnt_b - e1), 0);
      check_val("wrong_id_busy", (busy_cnt_a - b0) + (busy_cnt_b - b1), 0);
      cmp_events("wrong_id");

      d = {8'($urandom), 8'($urandom)};
      do_write(0, 8'hFF, d, 1'b1);
      cmp_events("wrap_inc");
      d = {8'($urandom), 8'($urandom)};
      do_write(1, 8'hFF, d, 1'b1);
      cmp_events("wrap_noinc");

      i2c_start();
      write_byte({id_of(0), 1'b0}, a); check_val("part_dev_ack", a, 1'b1);
      write_byte(8'h40, a);            check_val("part_reg_ack", a, 1'b1);
      mptr[0] = 8'h40;
      for (int i = 0; i < 5; i++) send_bit(1'($urandom), r);
      i2c_stop();
      m_sda = 1'b0; cyc(1); m_sda = 1'b1;
      cyc(4 * Q);
      check_val("part_busy", busy_a, 1'b0);
      check_val("part_sda_en", sda_en_a, 1'b0);
      cmp_events("partial");
      do_read(0, 1'b0, 8'h00, 1);
      cmp_events("ptr_retained");

      glitch_on = 1'b1;
      d = {8'h00, 8'h81, 8'($urandom)};
      do_write(0, 8'($urandom), d, 1'b1);
      glitch_on = 1'b0;
      cmp_events("glitch_write");

      i2c_start();
      b = 8'h78;
      for (int i = 7; i >= 0; i--) send_bit(b[i], r);
      found = 1'b0;
      for (int i = 0; i < 3 * Q && !found; i++) begin
         cyc(1);
         found = sda_en_a;
      end
      check_val("rst_ack_seen", found, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check_val("rst_async_sda", sda_en_a, 1'b0);
      check_val("rst_async_busy", busy_a, 1'b0);
      cyc(3);
      m_scl = 1'b1; cyc(2); m_sda = 1'b1; cyc(5);
      rst_n = 1'b1;
      cyc(4 * Q);
      mptr[0] = 8'h00;
      mptr[1] = 8'h00;
      obs_wr_a.delete(); obs_wr_b.delete(); obs_rd_a.delete(); obs_rd_b.delete();
      do_read(0, 1'b0, 8'h00, 1);
      d = {8'($urandom), 8'($urandom)};
      do_write(0, 8'($urandom), d, 1'b1);
      cmp_events("after_reset");

      for (int t = 0; t < 10; t++) begin
         int dev, n;
         dev = int'($urandom_range(1));
         n   = int'($urandom_range(3, 1));
         if ($urandom_range(1) == 0) begin
            d.delete();
            for (int k = 0; k < n; k++) d.push_back(8'($urandom));
            do_write(dev, 8'($urandom), d, 1'b1);
         end else begin
            do_read(dev, 1'($urandom), 8'($urandom), n);
         end
         cmp_events("random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
